// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, opcodes and decode types for the MIPS-subset core
package mips_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SIZEOP     = 6;
  localparam int DEF_SIZESA     = 5;
  localparam int DEF_IMEM_DEPTH = 64;
  localparam int DEF_DMEM_BYTES = 128;
  localparam int IMM_WIDTH      = 16;

  localparam logic [DEF_SIZEOP-1:0] OP_RTYPE = 6'b000000;
  localparam logic [DEF_SIZEOP-1:0] OP_ADDI  = 6'b001000;
  localparam logic [DEF_SIZEOP-1:0] OP_ANDI  = 6'b001100;
  localparam logic [DEF_SIZEOP-1:0] OP_ORI   = 6'b001101;
  localparam logic [DEF_SIZEOP-1:0] OP_LUI   = 6'b001111;
  localparam logic [DEF_SIZEOP-1:0] OP_LW    = 6'b100011;
  localparam logic [DEF_SIZEOP-1:0] OP_LB    = 6'b100000;
  localparam logic [DEF_SIZEOP-1:0] OP_LBU   = 6'b100100;
  localparam logic [DEF_SIZEOP-1:0] OP_SW    = 6'b101011;
  localparam logic [DEF_SIZEOP-1:0] OP_SB    = 6'b101000;
  localparam logic [DEF_SIZEOP-1:0] OP_BEQ   = 6'b000100;
  localparam logic [DEF_SIZEOP-1:0] OP_BNE   = 6'b000101;
  localparam logic [DEF_SIZEOP-1:0] OP_J     = 6'b000010;
  localparam logic [DEF_SIZEOP-1:0] OP_NOP   = 6'b111000;
  localparam logic [DEF_SIZEOP-1:0] OP_HALT  = 6'b111111;

  localparam logic [DEF_SIZEOP-1:0] FN_SLL   = 6'b000000;
  localparam logic [DEF_SIZEOP-1:0] FN_ADDU  = 6'b100001;
  localparam logic [DEF_SIZEOP-1:0] FN_SUBU  = 6'b100011;
  localparam logic [DEF_SIZEOP-1:0] FN_AND   = 6'b100100;
  localparam logic [DEF_SIZEOP-1:0] FN_OR    = 6'b100101;
  localparam logic [DEF_SIZEOP-1:0] FN_XOR   = 6'b100110;
  localparam logic [DEF_SIZEOP-1:0] FN_SLT   = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_LUI
  } alu_op_t;

  typedef enum logic [1:0] {
    LD_NONE,
    LD_WORD,
    LD_BYTE,
    LD_BYTEU
  } load_t;

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32-entry register file, two combinational reads, one posedge write
module mips_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     ra_addr,
  input  logic [ADDR_W-1:0]     rb_addr,
  output logic [DATA_WIDTH-1:0] ra_data,
  output logic [DATA_WIDTH-1:0] rb_data,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata
);

  localparam int NREGS = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  // Reset seeds Rn=n so programs have known operands; R0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= DATA_WIDTH'(i);
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mips_pipeline_top.sv
// rtl/mips_pipeline_top.sv - single-cycle MIPS-subset core with program-load port
module mips_pipeline_top
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SIZEOP     = DEF_SIZEOP,
  parameter int SIZESA     = DEF_SIZESA,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int DMEM_BYTES = DEF_DMEM_BYTES
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_instruccion,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic                  i_loading,
  output logic [DATA_WIDTH-1:0] o_result_wb
);

  localparam int PC_W    = $clog2(IMEM_DEPTH);
  localparam int DADDR_W = $clog2(DMEM_BYTES);

  logic [DATA_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [7:0]            dmem [DMEM_BYTES];
  logic [PC_W-1:0]       pc;
  logic                  halted;

  // Instruction fields
  logic [DATA_WIDTH-1:0] instr;
  logic [SIZEOP-1:0]     opcode;
  logic [SIZEOP-1:0]     funct;
  logic [SIZESA-1:0]     rs;
  logic [SIZESA-1:0]     rt;
  logic [SIZESA-1:0]     rd;
  logic [SIZESA-1:0]     shamt;
  logic [IMM_WIDTH-1:0]  imm;
  logic [DATA_WIDTH-1:0] sext_imm;
  logic [DATA_WIDTH-1:0] zext_imm;

  assign instr    = imem[pc];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign sext_imm = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign zext_imm = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};

  // Only the low index bits of the load address select an IMEM word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_address[DATA_WIDTH-1:PC_W];

  // Decode controls
  alu_op_t          alu_op;
  load_t            load_kind;
  logic             use_imm;
  logic             imm_zero_ext;
  logic             reg_we;
  logic             dest_is_rt;
  logic             is_store;
  logic             store_byte;
  logic             is_beq;
  logic             is_bne;
  logic             is_jump;
  logic             is_halt;

  // Decode opcode/funct into datapath controls; undefined encodings decode as NOP.
  always_comb begin
    alu_op       = ALU_ADD;
    load_kind    = LD_NONE;
    use_imm      = 1'b0;
    imm_zero_ext = 1'b0;
    reg_we       = 1'b0;
    dest_is_rt   = 1'b0;
    is_store     = 1'b0;
    store_byte   = 1'b0;
    is_beq       = 1'b0;
    is_bne       = 1'b0;
    is_jump      = 1'b0;
    is_halt      = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (funct)
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        use_imm = 1'b1; dest_is_rt = 1'b1; reg_we = 1'b1;
      end
      OP_ANDI: begin
        alu_op = ALU_AND; use_imm = 1'b1; imm_zero_ext = 1'b1;
        dest_is_rt = 1'b1; reg_we = 1'b1;
      end
      OP_ORI: begin
        alu_op = ALU_OR; use_imm = 1'b1; imm_zero_ext = 1'b1;
        dest_is_rt = 1'b1; reg_we = 1'b1;
      end
      OP_LUI: begin
        alu_op = ALU_LUI; dest_is_rt = 1'b1; reg_we = 1'b1;
      end
      OP_LW: begin
        use_imm = 1'b1; dest_is_rt = 1'b1; reg_we = 1'b1; load_kind = LD_WORD;
      end
      OP_LB: begin
        use_imm = 1'b1; dest_is_rt = 1'b1; reg_we = 1'b1; load_kind = LD_BYTE;
      end
      OP_LBU: begin
        use_imm = 1'b1; dest_is_rt = 1'b1; reg_we = 1'b1; load_kind = LD_BYTEU;
      end
      OP_SW:   begin use_imm = 1'b1; is_store = 1'b1; end
      OP_SB:   begin use_imm = 1'b1; is_store = 1'b1; store_byte = 1'b1; end
      OP_BEQ:  is_beq  = 1'b1;
      OP_BNE:  is_bne  = 1'b1;
      OP_J:    is_jump = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Register file
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;
  logic [SIZESA-1:0]     dest;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  run;
  logic                  commit_we;

  assign dest      = dest_is_rt ? rt : rd;
  assign run       = !i_loading && !halted;
  assign commit_we = run && reg_we && (dest != '0);

  mips_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (SIZESA)
  ) u_regfile (
    .clk     (i_clock),
    .rst_n   (i_reset),
    .ra_addr (rs),
    .rb_addr (rt),
    .ra_data (rs_data),
    .rb_data (rt_data),
    .we      (commit_we),
    .waddr   (dest),
    .wdata   (wb_data)
  );

  // ALU
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;

  assign alu_b = use_imm ? (imm_zero_ext ? zext_imm : sext_imm) : rt_data;

  // Arithmetic/logic result; also produces the effective address for loads/stores.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD: alu_result = rs_data + alu_b;
      ALU_SUB: alu_result = rs_data - alu_b;
      ALU_AND: alu_result = rs_data & alu_b;
      ALU_OR:  alu_result = rs_data | alu_b;
      ALU_XOR: alu_result = rs_data ^ alu_b;
      ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs_data) < $signed(alu_b))};
      ALU_SLL: alu_result = alu_b << shamt;
      ALU_LUI: alu_result = {imm, {(DATA_WIDTH-IMM_WIDTH){1'b0}}};
      default: alu_result = '0;
    endcase
  end

  // Data memory addressing: byte address wraps modulo the memory size.
  logic [DADDR_W-1:0]    dmem_addr;
  logic [DADDR_W-1:0]    b0_addr;
  logic [DADDR_W-1:0]    b1_addr;
  logic [DADDR_W-1:0]    b2_addr;
  logic [DADDR_W-1:0]    b3_addr;
  logic [7:0]            load_byte;
  logic [DATA_WIDTH-1:0] load_word;

  assign dmem_addr = alu_result[DADDR_W-1:0];
  assign b0_addr   = {dmem_addr[DADDR_W-1:2], 2'd0};
  assign b1_addr   = {dmem_addr[DADDR_W-1:2], 2'd1};
  assign b2_addr   = {dmem_addr[DADDR_W-1:2], 2'd2};
  assign b3_addr   = {dmem_addr[DADDR_W-1:2], 2'd3};
  assign load_byte = dmem[dmem_addr];
  assign load_word = {dmem[b3_addr], dmem[b2_addr], dmem[b1_addr], dmem[b0_addr]};

  // Select the write-back value: memory data for loads, ALU result otherwise.
  always_comb begin
    wb_data = alu_result;
    case (load_kind)
      LD_WORD:  wb_data = load_word;
      LD_BYTE:  wb_data = {{(DATA_WIDTH-8){load_byte[7]}}, load_byte};
      LD_BYTEU: wb_data = {{(DATA_WIDTH-8){1'b0}}, load_byte};
      default:  wb_data = alu_result;
    endcase
  end

  // Next PC: sequential, taken branch (relative to PC+1) or absolute jump, all modulo depth.
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] next_pc;
  logic            branch_taken;

  assign pc_plus1     = pc + 1'b1;
  assign branch_taken = (is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data));

  always_comb begin
    next_pc = pc_plus1;
    if (is_jump) begin
      next_pc = instr[PC_W-1:0];
    end else if (branch_taken) begin
      next_pc = pc_plus1 + sext_imm[PC_W-1:0];
    end
  end

  // Program load port; IMEM deliberately survives reset so a program can be rerun.
  always_ff @(posedge i_clock) begin
    if (i_reset && i_loading) begin
      imem[i_address[PC_W-1:0]] <= i_instruccion;
    end
  end

  // PC and halt flag: loading parks PC at 0 and clears a prior halt.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (i_loading) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      if (is_halt) begin
        halted <= 1'b1;
      end else begin
        pc <= next_pc;
      end
    end
  end

  // Observation register tracks every committed register write.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_result_wb <= '0;
    end else if (commit_we) begin
      o_result_wb <= wb_data;
    end
  end

  // Little-endian data memory; SW writes the aligned word, SB the addressed byte.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < DMEM_BYTES; i++) begin
        dmem[i] <= '0;
      end
    end else if (run && is_store) begin
      if (store_byte) begin
        dmem[dmem_addr] <= rt_data[7:0];
      end else begin
        dmem[b0_addr] <= rt_data[7:0];
        dmem[b1_addr] <= rt_data[15:8];
        dmem[b2_addr] <= rt_data[23:16];
        dmem[b3_addr] <= rt_data[31:24];
      end
    end
  end

endmodule

// File: tb/tb_mips_pipeline_top.sv
// tb/tb_mips_pipeline_top.sv - directed self-checking bench for mips_pipeline_top
`timescale 1ns/1ps
module tb_mips_pipeline_top;

  logic        i_clock;
  logic        i_reset;
  logic [31:0] i_instruccion;
  logic [31:0] i_address;
  logic        i_loading;
  logic [31:0] o_result_wb;

  int n_assert;
  int n_fail;

  mips_pipeline_top dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_instruccion (i_instruccion),
    .i_address     (i_address),
    .i_loading     (i_loading),
    .o_result_wb   (o_result_wb)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  logic [31:0] prog2 [11] = '{32'h00221821, 32'h00620821, 32'h20220FBD, 32'hA0220000,
                              32'h90270000, 32'hE0000000, 32'h00E11021, 32'h00221821,
                              32'h14270001, 32'hE0000000, 32'hFC000000};
  logic [31:0] exp2  [12] = '{32'd3, 32'd5, 32'd4034, 32'd4034, 32'd194, 32'd194,
                              32'd199, 32'd204, 32'd204, 32'd204, 32'd204, 32'd204};

  logic [31:0] prog4 [12] = '{32'h3C0A1122, 32'h354A3344, 32'hAC0A0008, 32'h800B000B,
                              32'h900C000B, 32'h8C0D0009, 32'h200E0080, 32'hA00E0014,
                              32'h800F0014, 32'h90100014, 32'hFC000000, 32'hE0000000};
  logic [31:0] exp4  [11] = '{32'h11220000, 32'h11223344, 32'h11223344, 32'h00000011,
                              32'h00000011, 32'h11223344, 32'h00000080, 32'h00000080,
                              32'hFFFFFF80, 32'h00000080, 32'h00000080};

  logic [31:0] prog6 [8]  = '{32'h00022900, 32'h00223023, 32'h00C1382A, 32'h08000005,
                              32'h20080063, 32'h00234826, 32'h00A35025, 32'hFC000000};
  logic [31:0] exp6  [8]  = '{32'd32, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd2, 32'd35, 32'd35, 32'd35};

  task automatic check(input string tag, input logic [31:0] expected);
    n_assert++;
    assert (o_result_wb === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, o_result_wb, expected);
    end
  endtask

  task automatic step_check(input string tag, input logic [31:0] expected);
    @(posedge i_clock);
    @(negedge i_clock);
    check(tag, expected);
  endtask

  task automatic load_word(input int addr, input logic [31:0] word);
    i_loading     = 1'b1;
    i_address     = addr;
    i_instruccion = word;
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  // Called at a negedge: async reset, check output cleared, release into load mode.
  task automatic do_reset(input string tag);
    i_reset   = 1'b0;
    i_loading = 1'b1;
    #1;
    check(tag, 32'd0);
    @(negedge i_clock);
    i_reset = 1'b1;
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    i_reset       = 1'b0;
    i_loading     = 1'b1;
    i_address     = '0;
    i_instruccion = '0;
    repeat (2) @(negedge i_clock);
    check("reset_wb", 32'd0);
    i_reset = 1'b1;

    // 1: ADDU r3=r1+r2 then HALT
    load_word(0, 32'h00221821);
    load_word(1, 32'hFC000000);
    check("load_no_wb", 32'd0);
    i_loading = 1'b0;
    step_check("t1_addu", 32'd3);
    for (int i = 0; i < 4; i++) step_check("t1_frozen", 32'd3);

    // 2: reference program
    do_reset("t2_reset");
    for (int i = 0; i < 11; i++) load_word(i, prog2[i]);
    i_loading = 1'b0;
    for (int i = 0; i < 12; i++) step_check($sformatf("t2_step%0d", i), exp2[i]);

    // 3: BEQ r1,r1,+1 skips ADDI
    do_reset("t3_reset");
    load_word(0, 32'h10210001);
    load_word(1, 32'h20250064);
    load_word(2, 32'h00221821);
    load_word(3, 32'hFC000000);
    i_loading = 1'b0;
    step_check("t3_beq", 32'd0);
    step_check("t3_after_skip", 32'd3);
    step_check("t3_halt", 32'd3);

    // 4: word/byte loads and stores
    do_reset("t4_reset");
    for (int i = 0; i < 12; i++) load_word(i, prog4[i]);
    i_loading = 1'b0;
    for (int i = 0; i < 11; i++) step_check($sformatf("t4_step%0d", i), exp4[i]);

    // 5: reset pulse mid-run, then rerun of the retained program
    do_reset("t5_reset");
    i_loading = 1'b0;
    step_check("t5_pre0", exp4[0]);
    step_check("t5_pre1", exp4[1]);
    i_reset = 1'b0;
    #1;
    check("t5_async_clear", 32'd0);
    #1;
    i_reset = 1'b1;
    for (int i = 0; i < 11; i++) step_check($sformatf("t5_rerun%0d", i), exp4[i]);

    // 6: write to R0 discarded; reload after HALT without reset
    do_reset("t6_reset");
    load_word(0, 32'h00220021);
    load_word(1, 32'h20040007);
    load_word(2, 32'hFC000000);
    i_loading = 1'b0;
    step_check("t6_r0_write", 32'd0);
    step_check("t6_r0_is_zero", 32'd7);
    step_check("t6_halt", 32'd7);
    step_check("t6_halted", 32'd7);
    for (int i = 0; i < 8; i++) load_word(i, prog6[i]);
    check("t6_load_hold", 32'd7);
    i_loading = 1'b0;
    for (int i = 0; i < 8; i++) step_check($sformatf("t6_rerun%0d", i), exp6[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
